// File: rtl/decode_reg_file_pkg.sv
// decode_reg_file_pkg: shared processor constants for the decode register file.
// No ports; provides default data width, register count and select width.
package decode_reg_file_pkg;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 4;
    localparam int SEL_W        = 2;
endpackage

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: pending-write scoreboard, issue hazard detection and sticky writeback error.
// Ports: clk, rst_n (async active-low); rd_en/rs1_sel/rs2_sel/dst_en/dst_sel/accept from decode;
// wb_en/wb_sel from writeback; kill_en/kill_sel drop a flushed destination;
// pending, hazard, wb_err outputs.
module decode_scoreboard
    import decode_reg_file_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REGS-1:0] rd_en,
    input  logic [SEL_W-1:0]    rs1_sel,
    input  logic [SEL_W-1:0]    rs2_sel,
    input  logic                dst_en,
    input  logic [SEL_W-1:0]    dst_sel,
    input  logic                accept,
    input  logic                wb_en,
    input  logic [SEL_W-1:0]    wb_sel,
    input  logic                kill_en,
    input  logic [SEL_W-1:0]    kill_sel,
    output logic [NUM_REGS-1:0] pending,
    output logic                hazard,
    output logic                wb_err
);
    logic [NUM_REGS-1:0] wb_hot, pend_eff, pend_nxt;

    always_comb begin
        wb_hot          = '0;
        wb_hot[wb_sel]  = wb_en;
        // a write landing this cycle already resolves its hazard (bypassed into the operand)
        pend_eff        = pending & ~wb_hot;
        hazard          = (rd_en[rs1_sel] & pend_eff[rs1_sel]) |
                          (rd_en[rs2_sel] & pend_eff[rs2_sel]) |
                          (dst_en & pend_eff[dst_sel]);
        pend_nxt        = pend_eff;
        if (kill_en) pend_nxt[kill_sel] = 1'b0;
        // a new issue wins over a same-cycle writeback to the same register
        if (accept && dst_en) pend_nxt[dst_sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            wb_err  <= 1'b0;
        end else begin
            pending <= pend_nxt;
            if (wb_en && !pending[wb_sel]) wb_err <= 1'b1;
        end
    end
endmodule

// File: rtl/decode_reg_file.sv
// decode_reg_file: register file with decode-stage operand read, bypass and execute operand register.
// Ports: clk, rst_n (async active-low); rd_en, rs1_sel, rs2_sel, id_valid/id_ready, id_dst_en/id_dst_sel
// from decode; wb_en/wb_sel/wb_data writeback; flush; ex_valid/ex_ready, rs1_data, rs2_data,
// ex_dst_en/ex_dst_sel to execute; pending scoreboard and sticky wb_err.
module decode_reg_file
    import decode_reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REGS-1:0] rd_en,
    input  logic [SEL_W-1:0]    rs1_sel,
    input  logic [SEL_W-1:0]    rs2_sel,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic                id_dst_en,
    input  logic [SEL_W-1:0]    id_dst_sel,
    input  logic                wb_en,
    input  logic [SEL_W-1:0]    wb_sel,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                flush,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [DATA_W-1:0]   rs1_data,
    output logic [DATA_W-1:0]   rs2_data,
    output logic                ex_dst_en,
    output logic [SEL_W-1:0]    ex_dst_sel,
    output logic [NUM_REGS-1:0] pending,
    output logic                wb_err
);
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] op1, op2;
    logic              hazard, accept;

    decode_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en),
        .rs1_sel  (rs1_sel),
        .rs2_sel  (rs2_sel),
        .dst_en   (id_dst_en),
        .dst_sel  (id_dst_sel),
        .accept   (accept),
        .wb_en    (wb_en),
        .wb_sel   (wb_sel),
        .kill_en  (flush & ex_valid & ex_dst_en),
        .kill_sel (ex_dst_sel),
        .pending  (pending),
        .hazard   (hazard),
        .wb_err   (wb_err)
    );

    assign id_ready = ~hazard & ~flush & (~ex_valid | ex_ready);
    assign accept   = id_valid & id_ready;
    // same-cycle writeback bypass takes priority; disabled reads return zero
    assign op1 = (wb_en && wb_sel == rs1_sel) ? wb_data : rd_en[rs1_sel] ? regs[rs1_sel] : '0;
    assign op2 = (wb_en && wb_sel == rs2_sel) ? wb_data : rd_en[rs2_sel] ? regs[rs2_sel] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[wb_sel] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_dst_en  <= 1'b0;
            ex_dst_sel <= '0;
            rs1_data   <= '0;
            rs2_data   <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid   <= 1'b1;
            ex_dst_en  <= id_dst_en;
            ex_dst_sel <= id_dst_sel;
            rs1_data   <= op1;
            rs2_data   <= op2;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_reg_file.sv
// tb_decode_reg_file: directed and random checks of decode_reg_file against a behavioural model.
module tb_decode_reg_file;
    logic        clk, rst_n;
    logic [3:0]  rd_en;
    logic [1:0]  rs1_sel, rs2_sel, id_dst_sel, wb_sel, ex_dst_sel;
    logic        id_valid, id_ready, id_dst_en, wb_en, flush, ex_valid, ex_ready, ex_dst_en, wb_err;
    logic [15:0] wb_data, rs1_data, rs2_data;
    logic [3:0]  pending;

    logic [15:0] m_regs [4];
    logic [3:0]  m_pend;
    logic        m_exv, m_dst_en, m_err, obs_rdy;
    logic [1:0]  m_dst_sel;
    logic [15:0] m_rs1, m_rs2;
    int          total = 0;
    int          bad = 0;

    decode_reg_file dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
        .id_valid(id_valid), .id_ready(id_ready), .id_dst_en(id_dst_en), .id_dst_sel(id_dst_sel),
        .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data), .flush(flush), .ex_valid(ex_valid),
        .ex_ready(ex_ready), .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_dst_en(ex_dst_en),
        .ex_dst_sel(ex_dst_sel), .pending(pending), .wb_err(wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] opnd(input logic [1:0] s);
        if (wb_en && wb_sel == s) return wb_data;
        return rd_en[s] ? m_regs[s] : 16'h0;
    endfunction

    task automatic idle();
        id_valid = 0; rd_en = 0; rs1_sel = 0; rs2_sel = 0; id_dst_en = 0; id_dst_sel = 0;
        wb_en = 0; wb_sel = 0; wb_data = 0; flush = 0; ex_ready = 1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        for (int r = 0; r < 4; r++) m_regs[r] = 0;
        m_pend = 0; m_exv = 0; m_dst_en = 0; m_dst_sel = 0; m_rs1 = 0; m_rs2 = 0; m_err = 0;
        #1;
        chk("rst/ex_valid", ex_valid, 0);
        chk("rst/rs1_data", rs1_data, 0);
        chk("rst/rs2_data", rs2_data, 0);
        chk("rst/ex_dst_en", ex_dst_en, 0);
        chk("rst/ex_dst_sel", ex_dst_sel, 0);
        chk("rst/pending", pending, 0);
        chk("rst/wb_err", wb_err, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    // one clock: check handshake before the edge, advance model, check registered state after it
    task automatic cyc(input string tag);
        logic [3:0] pe;
        logic       hz, rdy, acc;
        @(negedge clk);
        for (int r = 0; r < 4; r++) pe[r] = m_pend[r] && !(wb_en && wb_sel == r);
        hz  = (rd_en[rs1_sel] && pe[rs1_sel]) || (rd_en[rs2_sel] && pe[rs2_sel]) ||
              (id_dst_en && pe[id_dst_sel]);
        rdy = !hz && !flush && (!m_exv || ex_ready);
        acc = id_valid && rdy;
        obs_rdy = id_ready;
        chk({tag, "/id_ready"}, id_ready, rdy);
        @(posedge clk);
        if (wb_en && !m_pend[wb_sel]) m_err = 1;
        if (flush && m_exv && m_dst_en) m_pend[m_dst_sel] = 0;
        if (wb_en) m_pend[wb_sel] = 0;
        if (acc && id_dst_en) m_pend[id_dst_sel] = 1;
        if (flush) m_exv = 0;
        else if (acc) begin
            m_exv = 1; m_rs1 = opnd(rs1_sel); m_rs2 = opnd(rs2_sel);
            m_dst_en = id_dst_en; m_dst_sel = id_dst_sel;
        end else if (ex_ready) m_exv = 0;
        if (wb_en) m_regs[wb_sel] = wb_data;
        #1;
        chk({tag, "/ex_valid"}, ex_valid, m_exv);
        chk({tag, "/pending"}, pending, m_pend);
        chk({tag, "/wb_err"}, wb_err, m_err);
        if (m_exv) begin
            chk({tag, "/rs1_data"}, rs1_data, m_rs1);
            chk({tag, "/rs2_data"}, rs2_data, m_rs2);
            chk({tag, "/ex_dst_en"}, ex_dst_en, m_dst_en);
            chk({tag, "/ex_dst_sel"}, ex_dst_sel, m_dst_sel);
        end
    endtask

    initial begin
        rst_n = 1;
        idle();
        #2;
        do_reset();
        // preload registers
        wb_en = 1; wb_sel = 1; wb_data = 16'hAAAA; cyc("pre1");
        wb_sel = 2; wb_data = 16'h5555; cyc("pre2");
        wb_sel = 0; wb_data = 16'hFFFF; cyc("pre0");
        wb_sel = 3; wb_data = 16'h0303; cyc("pre3");
        // plain operand read
        idle(); id_valid = 1; rs1_sel = 1; rs2_sel = 2; rd_en = 4'b0110;
        cyc("read");
        chk("read/ex_valid_lit", ex_valid, 1);
        chk("read/rs1_lit", rs1_data, 16'hAAAA);
        chk("read/rs2_lit", rs2_data, 16'h5555);
        // read enables off give zero operands
        rd_en = 0; rs1_sel = 0; rs2_sel = 0;
        cyc("zero");
        chk("zero/rs1_lit", rs1_data, 0);
        chk("zero/rs2_lit", rs2_data, 0);
        // RAW hazard then bypass on writeback cycle
        id_dst_en = 1; id_dst_sel = 3;
        cyc("raw_issue");
        chk("raw_issue/pending_lit", pending, 4'b1000);
        id_dst_en = 0; rs1_sel = 3; rd_en = 4'b1000;
        repeat (2) begin
            cyc("raw_stall");
            chk("raw_stall/ready_lit", obs_rdy, 0);
        end
        wb_en = 1; wb_sel = 3; wb_data = 16'h1234;
        cyc("raw_wb");
        chk("raw_wb/ready_lit", obs_rdy, 1);
        chk("raw_wb/rs1_lit", rs1_data, 16'h1234);
        chk("raw_wb/pending_lit", pending, 0);
        // backpressure hold
        wb_en = 0; ex_ready = 0; rs1_sel = 1; rd_en = 4'b0010;
        repeat (3) begin
            cyc("hold");
            chk("hold/ready_lit", obs_rdy, 0);
            chk("hold/ex_valid_lit", ex_valid, 1);
            chk("hold/rs1_lit", rs1_data, 16'h1234);
        end
        ex_ready = 1;
        cyc("release");
        chk("release/rs1_lit", rs1_data, 16'hAAAA);
        idle();
        do_reset();
        // flush drops in-flight destination, then stray writeback flags error
        id_valid = 1; id_dst_en = 1; id_dst_sel = 2; ex_ready = 0;
        cyc("fl_issue");
        chk("fl_issue/pending_lit", pending, 4'b0100);
        id_valid = 0; id_dst_en = 0; flush = 1;
        cyc("flush");
        chk("flush/ex_valid_lit", ex_valid, 0);
        chk("flush/pending_lit", pending, 0);
        chk("flush/wb_err_lit", wb_err, 0);
        flush = 0; wb_en = 1; wb_sel = 2; wb_data = 16'h7777;
        cyc("fl_wb");
        chk("fl_wb/wb_err_lit", wb_err, 1);
        idle();
        do_reset();
        // asynchronous reset mid-stall
        id_valid = 1; id_dst_en = 1; id_dst_sel = 1;
        cyc("ar_a");
        id_dst_sel = 3;
        cyc("ar_b");
        chk("ar_b/pending_lit", pending, 4'b1010);
        ex_ready = 0; id_dst_sel = 0;
        cyc("ar_stall");
        #2;
        do_reset();
        // random traffic
        for (int n = 0; n < 400; n++) begin
            id_valid   = $urandom_range(0, 3) != 0;
            rd_en      = 4'($urandom_range(0, 15));
            rs1_sel    = 2'($urandom_range(0, 3));
            rs2_sel    = 2'($urandom_range(0, 3));
            id_dst_en  = $urandom_range(0, 1) == 1;
            id_dst_sel = 2'($urandom_range(0, 3));
            wb_en      = $urandom_range(0, 2) == 0;
            wb_sel     = 2'($urandom_range(0, 3));
            wb_data    = 16'($urandom);
            flush      = $urandom_range(0, 9) == 0;
            ex_ready   = $urandom_range(0, 2) != 0;
            cyc("rnd");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decode_reg_file.md
DECODE_REG_FILE -- requirements
Module: decode_reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 16: register and operand data width.
REQ-002 SHALL have parameter NUM_REGS, default 4: fixed register count, addressed by 2-bit selects.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port rd_en, input, 4: per-register read enables [s4..s1] from the decode read-enable decoder.
REQ-006 SHALL have ports rs1_sel and rs2_sel, input, 2 each: source register selects.
REQ-007 SHALL have ports id_valid (input, 1), id_ready (output, 1), id_dst_en (input, 1), id_dst_sel (input, 2): decode handshake and destination issued.
REQ-008 SHALL have ports wb_en (input, 1), wb_sel (input, 2), wb_data (input, DATA_W): writeback port.
REQ-009 SHALL have ports flush (input, 1), ex_valid (output, 1), ex_ready (input, 1), rs1_data and rs2_data (output, DATA_W each), ex_dst_en (output, 1), ex_dst_sel (output, 2): execute-side operand register.
REQ-010 SHALL have ports pending (output, 4) and wb_err (output, 1): scoreboard bits and sticky writeback error.

Function
REQ-011 SHALL hold NUM_REGS x DATA_W registers; none hardwired to zero.
REQ-012 SHALL write wb_data into reg[wb_sel] on a clock edge with wb_en=1.
REQ-013 SHALL define accept = id_valid & id_ready.
REQ-014 SHALL define hazard = any of: (rd_en[rs1_sel] & pend_eff[rs1_sel]); (rd_en[rs2_sel] & pend_eff[rs2_sel]); (id_dst_en & pend_eff[id_dst_sel]). pend_eff[r] = pending[r] & ~(wb_en & wb_sel==r).
REQ-015 SHALL drive id_ready = ~hazard & ~flush & (~ex_valid | ex_ready), combinationally.
REQ-016 SHALL, on accept, load rsN_data with: wb_data if wb_en & wb_sel==rsN_sel (bypass); else reg[rsN_sel] if rd_en[rsN_sel]=1; else 0.
REQ-017 SHALL, on accept, load ex_dst_en/ex_dst_sel from id_dst_en/id_dst_sel and set ex_valid=1 next cycle (latency 1).
REQ-018 SHALL hold all ex_* outputs and operand data stable while ex_valid & ~ex_ready.
REQ-019 SHALL clear ex_valid when ex_ready=1 and no accept occurs.
REQ-020 SHALL set pending[id_dst_sel] on accept with id_dst_en=1; SHALL clear pending[wb_sel] on wb_en; set wins when both target the same register in one cycle.
REQ-021 SHALL, on flush, clear ex_valid and clear pending[ex_dst_sel] if ex_valid & ex_dst_en; no accept occurs during flush.
REQ-022 SHALL set wb_err (sticky until reset) on wb_en to a register whose pending bit is 0; the write still occurs.

Reset
REQ-023 SHALL, on rst_n=0, asynchronously clear all registers, pending, ex_valid, ex_dst_en, ex_dst_sel, rs1_data, rs2_data, and wb_err to 0.
REQ-024 SHALL drive id_ready=1 from the first edge after reset release, provided ex_ready and flush allow it.

Structure
REQ-025 SHALL take DATA_W, NUM_REGS, and the 2-bit select width from the shared processor package.
REQ-026 SHALL place the pending/hazard logic in one sub-module, decode_scoreboard.

Verification
REQ-027 Verification SHALL cover: after reset, accept rs1=1, rs2=2, rd_en=0110, regs 0xAAAA/0x5555 -> next cycle ex_valid=1, rs1_data=0xAAAA, rs2_data=0x5555.
REQ-028 Verification SHALL cover: accept with dst=3, then id_valid with rs1=3, rd_en=1000 -> id_ready=0 until wb_en, wb_sel=3, wb_data=0x1234; in that wb cycle accept occurs with rs1_data=0x1234 (bypass).
REQ-029 Verification SHALL cover: rd_en=0000, rs1=rs2=0, reg0=0xFFFF -> rs1_data=rs2_data=0.
REQ-030 Verification SHALL cover: ex_valid=1, ex_ready=0 for 3 cycles with new id_valid -> id_ready=0 and outputs unchanged; ex_ready=1 -> new operands the next cycle.
REQ-031 Verification SHALL cover: flush with ex_dst_en=1, ex_dst_sel=2 -> ex_valid=0 and pending[2]=0 next cycle; wb_en to reg 2 afterwards -> wb_err=1.
REQ-032 Verification SHALL cover: rst_n low mid-stall with pending=1010 -> all outputs 0 immediately, independent of clk.
